// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared types and constants for the UART receive path.
//   rx_state_e  : receiver FSM state encoding (2 bits)
//   OVS_DEFAULT : default number of baud-tick pulses per bit
//   FRAME_BITS  : data bits per frame
//   majority3() : 2-of-3 vote used when UART_RX_MAJORITY_EN is defined
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int OVS_DEFAULT = 16;
  localparam int FRAME_BITS  = 8;

  // Two-of-three vote over consecutive tick samples of the line.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Bus between the UART receiver and the APB register block.
//   tick        : baud-oversample pulse (master -> slave)
//   rx          : asynchronous serial line, idle high (master -> slave)
//   rd_en       : pop request (master -> slave)
//   err_clr     : clear both sticky error flags (master -> slave)
//   rdata       : show-ahead FIFO head byte (slave -> master)
//   empty/full  : FIFO occupancy flags (slave -> master)
//   level       : FIFO byte count (slave -> master)
//   rx_done     : one-cycle pulse per completed frame (slave -> master)
//   frame_err   : sticky stop-bit error (slave -> master)
//   overrun_err : sticky dropped-byte error (slave -> master)
interface uart_rx_fifo_if #(
  parameter int DEPTH = 4
);

  logic                     tick;
  logic                     rx;
  logic                     rd_en;
  logic                     err_clr;
  logic [7:0]               rdata;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   level;
  logic                     rx_done;
  logic                     frame_err;
  logic                     overrun_err;

  modport master (
    output tick, rx, rd_en, err_clr,
    input  rdata, empty, full, level, rx_done, frame_err, overrun_err
  );

  modport slave (
    input  tick, rx, rd_en, err_clr,
    output rdata, empty, full, level, rx_done, frame_err, overrun_err
  );

endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// rx_byte_fifo
// Show-ahead byte FIFO with push/pop arbitration for the UART receiver.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i         : write request, pushData_i is the byte
//   pop_i          : read request (ignored while empty)
//   pushAccept_o   : push taken this cycle (room, or a pop frees a slot)
//   rdata_o        : head byte; holds the last head value while empty
//   empty_o/full_o : occupancy flags
//   level_o        : number of stored bytes
module rx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               pushData_i,
  input  logic                     pop_i,
  output logic                     pushAccept_o,
  output logic [7:0]               rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic [7:0]    hold_q;
  logic          popDo;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign level_o = count_q;

  // A full FIFO still accepts a push when the same cycle pops the head.
  // A pop against an empty FIFO is dropped, so push+pop while empty just writes.
  assign pushAccept_o = push_i && (!full_o || pop_i);
  assign popDo        = pop_i && !empty_o;

  assign rdata_o = empty_o ? hold_q : mem_q[rdPtr_q];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      if (pushAccept_o) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + AW'(1);
      end
      if (popDo) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({pushAccept_o, popDo})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      // Remember the visible head so rdata keeps it after the last pop.
      if (!empty_o) begin
        hold_q <= mem_q[rdPtr_q];
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// UART receiver: 2-flop synchroniser, oversampled start/data/stop FSM,
// sticky error flags and a show-ahead byte FIFO.
//   PCLK    : system clock, rising edge
//   PRESETn : asynchronous active-low reset
//   bus     : uart_rx_fifo_if.slave (tick, rx, rd_en, err_clr in;
//             rdata, empty, full, level, rx_done, frame_err, overrun_err out)
// Optional feature: define UART_RX_MAJORITY_EN to make every start, data and
// stop decision a 2-of-3 vote over the last three tick samples.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OVS   = OVS_DEFAULT
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  uart_rx_fifo_if.slave bus
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] START_SAMPLE = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] BIT_END      = TW'(OVS - 1);
  localparam logic [2:0]    LAST_BIT     = 3'(FRAME_BITS - 1);

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tickCnt_q, tickCnt_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          rxMeta_q, rxSync_q;
  logic          armed_q, armed_d;
  logic          rxDone_q, rxDone_d;
  logic          frameErr_q, frameErr_d;
  logic          overrunErr_q, overrunErr_d;
  logic          sampleBit;
  logic          stopDecision;
  logic          pushReq;
  logic          frameSet;
  logic          overrunSet;
  logic          pushAccept;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // The two previous tick samples; with the current one they form the vote
  // window ending at the decision tick.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      hist_q <= 2'b11;
    end else if (bus.tick) begin
      hist_q <= {hist_q[0], rxSync_q};
    end
  end

  assign sampleBit = majority3(hist_q[1], hist_q[0], rxSync_q);
`else
  assign sampleBit = rxSync_q;
`endif

  // FSM state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bit-timing counters; everything advances only on tick.
  // armed_q blocks a new start after a break until the line has been high.
  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    if (bus.tick) begin
      case (state_q)
        IDLE: begin
          if (!rxSync_q && armed_q) begin
            state_d   = START;
            tickCnt_d = '0;
          end
        end
        START: begin
          if (tickCnt_q == START_SAMPLE) begin
            if (sampleBit) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              tickCnt_d = '0;
              bitCnt_d  = '0;
            end
          end else begin
            tickCnt_d = tickCnt_q + TW'(1);
          end
        end
        DATA: begin
          if (tickCnt_q == BIT_END) begin
            shift_d   = {sampleBit, shift_q[7:1]};
            tickCnt_d = '0;
            bitCnt_d  = bitCnt_q + 3'd1;
            if (bitCnt_q == LAST_BIT) begin
              state_d = STOP;
            end
          end else begin
            tickCnt_d = tickCnt_q + TW'(1);
          end
        end
        STOP: begin
          if (tickCnt_q == BIT_END) begin
            state_d   = IDLE;
            tickCnt_d = '0;
          end else begin
            tickCnt_d = tickCnt_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: the stop-bit decision pushes, flags an error, or both
  // (refused push), and always produces the rx_done pulse.
  always_comb begin
    stopDecision = bus.tick && (state_q == STOP) && (tickCnt_q == BIT_END);
    pushReq      = stopDecision && sampleBit;
    frameSet     = stopDecision && !sampleBit;
    overrunSet   = pushReq && !pushAccept;
    rxDone_d     = stopDecision;
    frameErr_d   = frameSet   | (frameErr_q   & ~bus.err_clr);
    overrunErr_d = overrunSet | (overrunErr_q & ~bus.err_clr);
    armed_d      = rxSync_q ? 1'b1 : (frameSet ? 1'b0 : armed_q);
  end

  // Synchroniser, datapath registers and sticky flags.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rxMeta_q     <= 1'b1;
      rxSync_q     <= 1'b1;
      tickCnt_q    <= '0;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b1;
      rxDone_q     <= 1'b0;
      frameErr_q   <= 1'b0;
      overrunErr_q <= 1'b0;
    end else begin
      rxMeta_q     <= bus.rx;
      rxSync_q     <= rxMeta_q;
      tickCnt_q    <= tickCnt_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      rxDone_q     <= rxDone_d;
      frameErr_q   <= frameErr_d;
      overrunErr_q <= overrunErr_d;
    end
  end

  rx_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i        (PCLK),
    .rst_ni       (PRESETn),
    .push_i       (pushReq),
    .pushData_i   (shift_q),
    .pop_i        (bus.rd_en),
    .pushAccept_o (pushAccept),
    .rdata_o      (bus.rdata),
    .empty_o      (bus.empty),
    .full_o       (bus.full),
    .level_o      (bus.level)
  );

  assign bus.rx_done     = rxDone_q;
  assign bus.frame_err   = frameErr_q;
  assign bus.overrun_err = overrunErr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo with tick tied high, OVS=16, DEPTH=4.
// Frames are driven one line value per clock (16 clocks per bit); the
// expected bytes, levels and flags are written out by hand below.
// Honours UART_RX_MAJORITY_EN for the glitch-rejection expectation.
module tb_uart_rx_fifo;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  uart_rx_fifo_if #(.DEPTH(4)) ifc ();

  uart_rx_fifo #(
    .DEPTH(4),
    .OVS  (16)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (ifc)
  );

  always #5 PCLK = ~PCLK;

  int checkCount     = 0;
  int passCount      = 0;
  int doneCount      = 0;
  logic doneLast     = 1'b0;
  logic emptyAfterDone = 1'b1;
  int doneBefore;
  logic [7:0] glitchExpect;

  // Counts rx_done pulses and records empty one cycle after each pulse.
  always @(negedge PCLK) begin
    if (doneLast) emptyAfterDone = ifc.empty;
    doneLast = ifc.rx_done;
    if (ifc.rx_done) doneCount++;
  end

  // Single comparison point: counts, and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // Drives one frame, LSB first. glitchAt inverts one clock of the line,
  // popAt raises rd_en for one clock, abortAt stops driving mid-frame.
  task automatic applyStimulus(input logic [7:0] data, input logic stopVal,
                               input int glitchAt, input int popAt, input int abortAt);
    logic bitVal;
    int idx;
    for (int c = 0; c < 160; c++) begin
      @(negedge PCLK);
      if (c == abortAt) return;
      idx = c / 16;
      if (idx == 0)      bitVal = 1'b0;
      else if (idx == 9) bitVal = stopVal;
      else               bitVal = data[idx-1];
      if (c == glitchAt) bitVal = ~bitVal;
      ifc.rx    = bitVal;
      ifc.rd_en = (c == popAt);
    end
    @(negedge PCLK);
    ifc.rx    = 1'b1;
    ifc.rd_en = 1'b0;
    idleCycles(4);
  endtask

  task automatic popByte(input string tag, input logic [7:0] exp);
    @(negedge PCLK);
    checkOutput(tag, 32'(ifc.rdata), 32'(exp));
    ifc.rd_en = 1'b1;
    @(negedge PCLK);
    ifc.rd_en = 1'b0;
  endtask

  task automatic clearErrors();
    @(negedge PCLK);
    ifc.err_clr = 1'b1;
    @(negedge PCLK);
    ifc.err_clr = 1'b0;
  endtask

  initial begin
    ifc.tick    = 1'b1;
    ifc.rx      = 1'b1;
    ifc.rd_en   = 1'b0;
    ifc.err_clr = 1'b0;
    idleCycles(3);

    // Reset state.
    checkOutput("rst_empty",   32'(ifc.empty),       32'd1);
    checkOutput("rst_full",    32'(ifc.full),        32'd0);
    checkOutput("rst_level",   32'(ifc.level),       32'd0);
    checkOutput("rst_done",    32'(ifc.rx_done),     32'd0);
    checkOutput("rst_ferr",    32'(ifc.frame_err),   32'd0);
    checkOutput("rst_oerr",    32'(ifc.overrun_err), 32'd0);
    checkOutput("rst_rdata",   32'(ifc.rdata),       32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    idleCycles(4);

    // Clean 0xA5 frame.
    doneBefore = doneCount;
    applyStimulus(8'hA5, 1'b1, -1, -1, -1);
    checkOutput("a5_done",     32'(doneCount - doneBefore), 32'd1);
    checkOutput("a5_emptyNxt", 32'(emptyAfterDone),         32'd0);
    checkOutput("a5_rdata",    32'(ifc.rdata),              32'hA5);
    checkOutput("a5_level",    32'(ifc.level),              32'd1);
    checkOutput("a5_ferr",     32'(ifc.frame_err),          32'd0);
    checkOutput("a5_oerr",     32'(ifc.overrun_err),        32'd0);
    popByte("a5_pop", 8'hA5);
    checkOutput("a5_emptyAft", 32'(ifc.empty),              32'd1);
    checkOutput("a5_holdData", 32'(ifc.rdata),              32'hA5);

    // Three-clock low glitch: false start.
    doneBefore = doneCount;
    @(negedge PCLK); ifc.rx = 1'b0;
    idleCycles(2);
    @(negedge PCLK); ifc.rx = 1'b1;
    idleCycles(40);
    checkOutput("glitch_done",  32'(doneCount - doneBefore), 32'd0);
    checkOutput("glitch_empty", 32'(ifc.empty),              32'd1);

    // 0x3C with a low stop bit.
    doneBefore = doneCount;
    applyStimulus(8'h3C, 1'b0, -1, -1, -1);
    checkOutput("ferr_done",  32'(doneCount - doneBefore), 32'd1);
    checkOutput("ferr_flag",  32'(ifc.frame_err),          32'd1);
    checkOutput("ferr_level", 32'(ifc.level),              32'd0);
    clearErrors();
    checkOutput("ferr_clr",   32'(ifc.frame_err),          32'd0);

    // Break: line low for many frame times yields a single frame error.
    doneBefore = doneCount;
    @(negedge PCLK); ifc.rx = 1'b0;
    idleCycles(400);
    @(negedge PCLK); ifc.rx = 1'b1;
    idleCycles(20);
    checkOutput("brk_done",  32'(doneCount - doneBefore), 32'd1);
    checkOutput("brk_ferr",  32'(ifc.frame_err),          32'd1);
    checkOutput("brk_level", 32'(ifc.level),              32'd0);
    clearErrors();

    // Five frames, no pops: fifth byte overruns.
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, -1, -1, -1);
    checkOutput("ovr_full",  32'(ifc.full),        32'd1);
    checkOutput("ovr_level", 32'(ifc.level),       32'd4);
    checkOutput("ovr_flag",  32'(ifc.overrun_err), 32'd1);
    checkOutput("ovr_ferr",  32'(ifc.frame_err),   32'd0);
    for (int i = 1; i <= 4; i++) popByte("ovr_pop", 8'(i));
    checkOutput("ovr_empty", 32'(ifc.empty),       32'd1);
    clearErrors();
    checkOutput("ovr_clr",   32'(ifc.overrun_err), 32'd0);

    // Full FIFO, pop lands on the fifth frame's stop-sample clock.
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1, -1, -1, -1);
    applyStimulus(8'h05, 1'b1, -1, 154, -1);
    checkOutput("sim_level", 32'(ifc.level),       32'd4);
    checkOutput("sim_full",  32'(ifc.full),        32'd1);
    checkOutput("sim_oerr",  32'(ifc.overrun_err), 32'd0);
    checkOutput("sim_head",  32'(ifc.rdata),       32'h02);
    for (int i = 2; i <= 5; i++) popByte("sim_pop", 8'(i));
    checkOutput("sim_empty", 32'(ifc.empty),       32'd1);

    // Reset in the middle of a frame with two bytes stored.
    applyStimulus(8'h11, 1'b1, -1, -1, -1);
    applyStimulus(8'h22, 1'b1, -1, -1, -1);
    checkOutput("mrst_pre",  32'(ifc.level), 32'd2);
    applyStimulus(8'h33, 1'b1, -1, -1, 50);
    PRESETn = 1'b0;
    ifc.rx  = 1'b1;
    idleCycles(2);
    checkOutput("mrst_empty", 32'(ifc.empty),       32'd1);
    checkOutput("mrst_level", 32'(ifc.level),       32'd0);
    checkOutput("mrst_ferr",  32'(ifc.frame_err),   32'd0);
    checkOutput("mrst_oerr",  32'(ifc.overrun_err), 32'd0);
    checkOutput("mrst_rdata", 32'(ifc.rdata),       32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    idleCycles(4);
    applyStimulus(8'h5A, 1'b1, -1, -1, -1);
    checkOutput("mrst_5a",    32'(ifc.rdata), 32'h5A);
    checkOutput("mrst_lvl1",  32'(ifc.level), 32'd1);
    popByte("mrst_pop", 8'h5A);

    // 0x00 with a one-clock high glitch on the bit-3 decision sample.
`ifdef UART_RX_MAJORITY_EN
    glitchExpect = 8'h00;
`else
    glitchExpect = 8'h08;
`endif
    applyStimulus(8'h00, 1'b1, 72, -1, -1);
    checkOutput("maj_rdata", 32'(ifc.rdata), 32'(glitchExpect));
    checkOutput("maj_level", 32'(ifc.level), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side companion to the APB UART transmit path.
- Deserialises the asynchronous rx line using the shared 16x baud tick, checks the stop bit, and buffers received bytes in a small show-ahead FIFO.
- The APB slave register block pops bytes from the FIFO and reads status and sticky error flags.
- Sits between the rx pad and the APB register interface.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- OVS, 16, tick pulses per bit; even, ≥8.

Ports:
- PCLK  in  1  system clock; all logic rising-edge.
- PRESETn  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle baud-oversample pulse from tick generator.
- rx  in  1  asynchronous serial input; idle high.
- rd_en  in  1  pop request from register block.
- err_clr  in  1  clears both sticky error flags.
- rdata  out  8  FIFO head byte, show-ahead.
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds DEPTH bytes.
- level  out  $clog2(DEPTH)+1  current byte count.
- rx_done  out  1  one-cycle pulse per completed frame, whether accepted or rejected.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun_err  out  1  sticky: good byte dropped because FIFO full.

Behaviour:
- Reset values (PRESETn low, asynchronous): FSM IDLE, all counters 0, shift register 0, synchroniser flops 1, FIFO emptied, empty=1, full=0, level=0, rx_done=0, both error flags 0, rdata=0.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- tick_cnt counts tick pulses within a bit; the FSM only advances on cycles with tick=1.
- IDLE: when rx_s==0, go to START with tick_cnt=0.
- START:
  - At tick_cnt==OVS/2-1, sample the line.
  - If sampled 1: false start, return to IDLE, nothing pushed.
  - If sampled 0: tick_cnt=0, bit_cnt=0, go to DATA.
  - Otherwise increment tick_cnt.
- DATA:
  - At tick_cnt==OVS-1, shift the sample into the MSB of the shift register (LSB-first on the line), tick_cnt=0, increment bit_cnt.
  - After the 8th bit, go to STOP.
- STOP: at tick_cnt==OVS-1, sample the line, then go to IDLE and pulse rx_done for one cycle.
  - Sample 1 and push accepted: byte written.
  - Sample 1 and push refused: byte dropped, overrun_err set.
  - Sample 0: byte dropped, frame_err set, no push.
- Push acceptance: a push is accepted when full==0, or when rd_en==1 in the same cycle.
- Latency: the byte appears on rdata with empty=0 on the cycle after the STOP sample cycle.
- FIFO:
  - rdata = mem[rd_ptr] whenever empty==0; holds its last value when empty.
  - Pointers wrap modulo DEPTH.
  - rd_en while empty: ignored, no pointer movement, no error.
- Simultaneous push and pop:
  - When empty: the push takes effect, the pop is ignored, level becomes 1.
  - When full: both take effect, level stays DEPTH, overrun_err not set.
  - Otherwise: both take effect, level unchanged.
- Error flags: a set in the same cycle as err_clr wins, so the flag stays 1.
- Break (rx held low indefinitely): frame_err set once per frame; the FSM re-enters START only after rx_s returns high and then falls again.
- PRESETn asserted mid-frame: frame abandoned, FIFO contents lost.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each START, DATA and STOP decision uses a 2-of-3 majority.
  - START samples at tick_cnt OVS/2-3, OVS/2-2 and OVS/2-1.
  - DATA and STOP sample at OVS-3, OVS-2 and OVS-1.
  - Decision timing is unchanged.
- Undefined: a single sample at the decision tick; no sample history registers exist.

Decomposition:
- Package uart_rx_pkg holds:
  - rx_state_e enum (IDLE, START, DATA, STOP; 2 bits).
  - Default OVS constant.
  - Frame bit count constant (8).
- Sub-module rx_byte_fifo holds the storage, pointers, full/empty/level and push/pop arbitration; it is parameterised by DEPTH.
- The FSM, synchroniser and error flags live in the top level.

Test Plan:
- tick tied high, OVS=16: drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) at 16 cycles/bit → rx_done pulses once, empty falls the next cycle, rdata=0xA5, level=1, no errors.
- 3-cycle low glitch on idle rx → FSM returns to IDLE at the start check, rx_done never pulses, empty stays 1.
- Frame 0x3C with stop bit driven low → frame_err=1, level unchanged, rx_done pulses; err_clr pulse → frame_err=0.
- Send 5 good frames (0x01–0x05) with DEPTH=4 and no pops → full=1, level=4, overrun_err=1, pops return 0x01..0x04, then empty=1.
- With FIFO full, assert rd_en exactly on the 5th frame's STOP sample cycle → level stays 4, overrun_err=0, head becomes 0x02, tail holds 0x05.
- Assert PRESETn low mid-DATA of a frame while level=2 → empty=1, level=0, flags 0; a subsequent clean 0x5A frame is received correctly.
- With UART_RX_MAJORITY_EN defined: one-cycle-inverted glitch at tick OVS-1 of bit 3 of 0x00 → rdata=0x00. Without the macro, the same stimulus gives rdata=0x08.
